pipeline_hazard_responder: RTL
==============================

Name: pipeline_hazard_responder

Overview:
- Consumer end of the hazard-detection interface: it applies pcHOLD / IFIDRegHOLD / IFflush / controlMUX to the real pipeline state.
- Owns the PC register, the IF/ID pipeline register and the control half of the ID/EX register (bubble insertion).
- Adds a stall watchdog and saturating stall/flush event counters for debug.
- Sits between the instruction memory / next-PC logic and the ID stage of the 5-stage MIPS core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CTRL_W, 10, width of the ID-stage control word carried into ID/EX.
- MAX_STALL, 4, consecutive hold cycles that trip the watchdog (legal range 2..15).
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_hold  in  1  freeze PC (from hazard unit pcHOLD).
- ifid_hold  in  1  freeze IF/ID (IFIDRegHOLD).
- if_flush  in  1  squash fetched instruction (IFflush).
- ctrl_mux  in  1  force bubble into ID/EX control (controlMUX).
- branch_taken  in  1  redirect fetch this cycle.
- branch_target  in  32  redirect address.
- imem_instr  in  32  instruction at current pc.
- id_ctrl  in  CTRL_W  decoded control word from the ID stage.
- clr_counters  in  1  synchronous clear of counters and watchdog.
- pc  out  32  current fetch address.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc_plus4  out  32  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction.
- idex_ctrl  out  CTRL_W  ID/EX control word.
- stall_cnt  out  CNT_W  cycles with pc_hold asserted (saturating).
- flush_cnt  out  CNT_W  cycles in which an IF/ID flush took effect (saturating).
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; ifid_instr=0; ifid_pc_plus4=0; ifid_valid=0; idex_ctrl=0.
  - stall_cnt=0; flush_cnt=0; stall_timeout=0; FSM=RUN.
  - Reset mid-stall discards the held state entirely.
- PC update, per rising edge, priority order:
  - pc_hold: pc unchanged, branch_taken ignored (the hazard unit re-presents the branch).
  - else branch_taken: pc=branch_target.
  - else pc=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- IF/ID update, priority order:
  - ifid_hold: all IF/ID fields unchanged. Hold beats flush, because the load-use case asserts both.
  - else if_flush: ifid_instr=0 (nop), ifid_pc_plus4=0, ifid_valid=0; flush_cnt increments.
  - else: ifid_instr=imem_instr, ifid_pc_plus4=pc+4, ifid_valid=1.
- ID/EX control:
  - idex_ctrl = ctrl_mux ? 0 : id_ctrl, registered.
  - Bubble latency 1 cycle: ctrl_mux seen at edge N gives idex_ctrl=0 after edge N.
- Watchdog FSM, evaluated per edge:
  - RUN: pc_hold=1 -> STALL with run counter=1.
  - STALL: pc_hold=1 -> counter+1; when counter reaches MAX_STALL -> TRIP and set stall_timeout. pc_hold=0 -> RUN with counter=0.
  - TRIP: stall_timeout stays 1 regardless of inputs; leaves only via rst_n or clr_counters (-> RUN).
  - The PC/IF/ID datapath is unaffected by the FSM state.
- Counters:
  - stall_cnt increments on every edge with pc_hold=1.
  - Both counters saturate at all-ones.
  - clr_counters=1 zeroes both counters and the run counter, clears stall_timeout and sets FSM=RUN. It overrides any same-cycle increment.
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - NOP_INSTR (32'h0) and RESET_PC default.
  - The CTRL_W constant shared with the control unit.
  - FSM state enum {RUN, STALL, TRIP}.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated twice.
- PC and IF/ID logic stay inline.

Test Plan:
- Reset then 3 free cycles:
  - pc sequence 0, 4, 8, 12.
  - ifid_instr follows imem_instr delayed by 1; ifid_valid=1 after the first edge.
- Load-use: pc_hold=ifid_hold=if_flush=ctrl_mux=1 for 1 cycle at pc=8:
  - pc stays 8 and IF/ID is unchanged (hold beats flush).
  - idex_ctrl=0 next cycle; stall_cnt=1; flush_cnt=0.
- Branch: if_flush=ctrl_mux=1 and branch_taken=1 with target 0x40, no hold:
  - pc=0x40, ifid_instr=0, ifid_valid=0, idex_ctrl=0, flush_cnt=1.
- Hold+branch in the same cycle: pc_hold=1, branch_taken=1, target 0x80 -> pc unchanged.
- Watchdog with MAX_STALL=4, pc_hold high for 4 cycles:
  - stall_timeout=1 after the 4th edge and stays 1 after pc_hold drops.
  - clr_counters pulse -> stall_timeout=0, stall_cnt=0.
- Wrap and saturation, plus async reset:
  - Force pc to 32'hFFFF_FFFC -> next pc=0.
  - With CNT_W=4, 17 flushes -> flush_cnt=15.
  - rst_n low mid-cycle -> all outputs reset immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Constants and types shared by the fetch/decode pipeline registers of the 5-stage MIPS core.
package mips_pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned CTRL_W_DEFAULT   = 10;

  // Watchdog run counter is sized for the largest legal MAX_STALL (15).
  localparam int unsigned RUN_CNT_W = 4;

  typedef enum logic [1:0] {
    StRun,
    StStall,
    StTrip
  } wd_state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; a synchronous clear overrides a same-cycle increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_responder.sv
// Applies hazard-unit hold/flush/bubble requests to the PC, IF/ID and ID/EX control registers,
// and watches for runaway stalls.
module pipeline_hazard_responder
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned CTRL_W    = CTRL_W_DEFAULT,
  parameter int unsigned MAX_STALL = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_hold_i,
  input  logic              ifid_hold_i,
  input  logic              if_flush_i,
  input  logic              ctrl_mux_i,
  input  logic              branch_taken_i,
  input  logic [31:0]       branch_target_i,
  input  logic [31:0]       imem_instr_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              clr_counters_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       ifid_instr_o,
  output logic [31:0]       ifid_pc_plus4_o,
  output logic              ifid_valid_o,
  output logic [CTRL_W-1:0] idex_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic              stall_timeout_o
);

  localparam logic [RUN_CNT_W-1:0] MaxStall = RUN_CNT_W'(MAX_STALL);
  localparam logic [RUN_CNT_W-1:0] RunOne   = RUN_CNT_W'(1);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       pc_plus4;
  logic [31:0]       ifid_instr_q, ifid_instr_d;
  logic [31:0]       ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
  logic              flush_fire;

  wd_state_e             state_q;
  logic [RUN_CNT_W-1:0]  run_cnt_q;
  logic                  timeout_q;

  assign pc_plus4 = pc_q + 32'd4;

  // A held PC ignores the branch: the hazard unit re-presents it once the stall clears.
  always_comb begin
    pc_d = pc_q;
    if (!pc_hold_i) begin
      pc_d = branch_taken_i ? branch_target_i : pc_plus4;
    end
  end

  // Hold wins over flush so the load-use case keeps the dependent instruction in ID.
  assign flush_fire = if_flush_i && !ifid_hold_i;

  always_comb begin
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    if (!ifid_hold_i) begin
      if (if_flush_i) begin
        ifid_instr_d    = NOP_INSTR;
        ifid_pc_plus4_d = '0;
        ifid_valid_d    = 1'b0;
      end else begin
        ifid_instr_d    = imem_instr_i;
        ifid_pc_plus4_d = pc_plus4;
        ifid_valid_d    = 1'b1;
      end
    end
  end

  assign idex_ctrl_d = ctrl_mux_i ? '0 : id_ctrl_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
      idex_ctrl_q     <= '0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      idex_ctrl_q     <= idex_ctrl_d;
    end
  end

  // Watchdog: counts consecutive pc_hold cycles; the trip is sticky until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else if (clr_counters_i) begin
      state_q   <= StRun;
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (pc_hold_i) begin
            state_q   <= StStall;
            run_cnt_q <= RunOne;
          end
        end
        StStall: begin
          if (pc_hold_i) begin
            run_cnt_q <= run_cnt_q + RunOne;
            if ((run_cnt_q + RunOne) == MaxStall) begin
              state_q   <= StTrip;
              timeout_q <= 1'b1;
            end
          end else begin
            state_q   <= StRun;
            run_cnt_q <= '0;
          end
        end
        StTrip: begin
          timeout_q <= 1'b1;
        end
        default: begin
          state_q   <= StRun;
          run_cnt_q <= '0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pc_hold_i),
    .clr_i (clr_counters_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_fire),
    .clr_i (clr_counters_i),
    .cnt_o (flush_cnt_o)
  );

  assign pc_o            = pc_q;
  assign ifid_instr_o    = ifid_instr_q;
  assign ifid_pc_plus4_o = ifid_pc_plus4_q;
  assign ifid_valid_o    = ifid_valid_q;
  assign idex_ctrl_o     = idex_ctrl_q;
  assign stall_timeout_o = timeout_q;

endmodule
